car_control_fsm_gen: RTL and testbench

Parametrised successor to the single-car lane controller. It moves a player car horizontally between two track walls, using a clock-divided movement tick. While a direction button is held, the step size accelerates. Collisions with a wall or a rival cost a life: a collision with lives remaining waits in CRASH for a respawn, and losing the last life ends in GAME_OVER. It sits between the debounced button inputs, the rival/collision detector, and the VGA renderer, which consumes `car_x` and `running`.

---
 rtl/car_control_fsm_gen.sv | 137 +++++++++++++
 tb/tb_car_control_fsm_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/car_control_fsm_gen.sv
// Player-car lane controller: tick-paced horizontal movement with step
// acceleration, wall/rival crashes, lives and respawn handling.
module car_control_fsm_gen #(
  parameter int TICK_DIV    = 10_000_000,
  parameter int X_W         = 10,
  parameter int TRACK_LEFT  = 244,
  parameter int TRACK_RIGHT = 318,
  parameter int CAR_W       = 14,
  parameter int START_X     = 270,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 4,
  parameter int LIVES       = 3,
  localparam int LW         = $clog2(LIVES+1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           btn_center,
  input  logic           rival_collision,
  output logic           running,
  output logic           game_over,
  output logic           crash_pulse,
  output logic [X_W-1:0] car_x,
  output logic [LW-1:0]  lives_left,
  output logic [2:0]     state
);
  localparam int CW  = $clog2(TICK_DIV);
  localparam int SW  = $clog2(STEP_MAX+1);
  localparam int XW1 = X_W + 1;

  typedef enum logic [2:0] {
    S_START = 3'd0, S_IDLE = 3'd1, S_RIGHT = 3'd2,
    S_LEFT  = 3'd3, S_CRASH = 3'd4, S_OVER = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [X_W-1:0]  car_x_q, car_x_d;
  logic [SW-1:0]   step_q, step_d;
  logic [LW-1:0]   lives_q, lives_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rival_q, crash_q, crash_d;
  logic            tick, active, hold, wall;
  logic [XW1-1:0]  right_edge, left_lim;
  logic            hit_r, hit_l;
  logic [SW-1:0]   step_inc;

  assign tick       = (cnt_q == CW'(TICK_DIV-1));
  assign active     = (state_q == S_START) || (state_q == S_IDLE) ||
                      (state_q == S_RIGHT) || (state_q == S_LEFT);
  // Wall tests are done one bit wider so the sum cannot wrap.
  assign right_edge = {1'b0, car_x_q} + XW1'(step_q) + XW1'(CAR_W);
  assign left_lim   = XW1'(TRACK_LEFT) + XW1'(step_q);
  assign hit_r      = right_edge >= XW1'(TRACK_RIGHT);
  assign hit_l      = {1'b0, car_x_q} <= left_lim;
  assign step_inc   = (step_q >= SW'(STEP_MAX)) ? SW'(STEP_MAX) : step_q + SW'(1);

  always_comb begin
    state_d = state_q;
    car_x_d = car_x_q;
    step_d  = step_q;
    lives_d = lives_q;
    crash_d = 1'b0;
    hold    = 1'b0;
    wall    = 1'b0;
    case (state_q)
      S_START: state_d = S_IDLE;
      S_IDLE:  if (btn_left ^ btn_right) state_d = btn_left ? S_LEFT : S_RIGHT;
      S_RIGHT, S_LEFT: begin
        hold = (state_q == S_RIGHT) ? (btn_right & ~btn_left) : (btn_left & ~btn_right);
        if (tick) begin
          if (state_q == S_RIGHT) begin
            if (hit_r) begin
              car_x_d = X_W'(TRACK_RIGHT - CAR_W);
              wall    = 1'b1;
            end else begin
              car_x_d = car_x_q + X_W'(step_q);
              step_d  = step_inc;
            end
          end else begin
            if (hit_l) begin
              car_x_d = X_W'(TRACK_LEFT);
              wall    = 1'b1;
            end else begin
              car_x_d = car_x_q - X_W'(step_q);
              step_d  = step_inc;
            end
          end
        end
        if (!hold) state_d = S_IDLE;
      end
      S_CRASH: if (btn_center) state_d = S_START;
      S_OVER: if (btn_center) begin
        state_d = S_START;
        lives_d = LW'(LIVES);
      end
      default: state_d = S_START;
    endcase
    // A crash overrides whatever the buttons asked for.
    if (active && (rival_q || wall)) begin
      crash_d = 1'b1;
      lives_d = lives_q - LW'(1);
      state_d = (lives_q == LW'(1)) ? S_OVER : S_CRASH;
    end
    if (state_d != S_RIGHT && state_d != S_LEFT) step_d = SW'(STEP_MIN);
    if (state_d == S_START) car_x_d = X_W'(START_X);
    if (state_d == S_START || tick) cnt_d = '0;
    else                            cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_START;
      car_x_q <= X_W'(START_X);
      step_q  <= SW'(STEP_MIN);
      lives_q <= LW'(LIVES);
      cnt_q   <= '0;
      rival_q <= 1'b0;
      crash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      car_x_q <= car_x_d;
      step_q  <= step_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      rival_q <= rival_collision;
      crash_q <= crash_d;
    end
  end

  assign running     = active;
  assign game_over   = (state_q == S_OVER);
  assign crash_pulse = crash_q;
  assign car_x       = car_x_q;
  assign lives_left  = lives_q;
  assign state       = state_q;
endmodule

// File: tb/tb_car_control_fsm_gen.sv
// Bench for car_control_fsm_gen: integer game model checked every cycle,
// plus directed scenarios with literal expected positions and states.
module tb_car_control_fsm_gen;
  localparam int TICK_DIV = 4, X_W = 10, TL = 244, TR = 318, CARW = 14, SX = 270;
  localparam int SMIN = 1, SMAX = 4, LIVES = 3, LW = $clog2(LIVES+1);

  logic clk = 1'b0, reset = 1'b1;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_center = 1'b0, rival_collision = 1'b0;
  logic running, game_over, crash_pulse;
  logic [X_W-1:0] car_x;
  logic [LW-1:0]  lives_left;
  logic [2:0]     state;

  int n_tests = 0, n_fail = 0;
  int m_st, m_x, m_step, m_lives, m_cnt, m_riv, m_pulse;
  int nst, nx, nstep, nl, dir;
  bit crash, tick, hold;

  car_control_fsm_gen #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .btn_center(btn_center), .rival_collision(rival_collision),
    .running(running), .game_over(game_over), .crash_pulse(crash_pulse),
    .car_x(car_x), .lives_left(lives_left), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game model: positions and lives as plain integers, one update per edge.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_st = 0; m_x = SX; m_step = SMIN; m_lives = LIVES; m_cnt = 0; m_riv = 0; m_pulse = 0;
    end else begin
      tick = (m_cnt == TICK_DIV-1);
      nst = m_st; nx = m_x; nstep = m_step; nl = m_lives; crash = 0;
      if (m_st == 0) nst = 1;
      else if (m_st == 1) begin
        if (btn_left && !btn_right) nst = 3;
        if (btn_right && !btn_left) nst = 2;
      end else if (m_st == 2 || m_st == 3) begin
        dir  = (m_st == 2) ? 1 : -1;
        hold = (dir > 0) ? (btn_right && !btn_left) : (btn_left && !btn_right);
        if (tick) begin
          if (dir > 0 && m_x + m_step + CARW >= TR) begin nx = TR - CARW; crash = 1; end
          else if (dir < 0 && m_x <= TL + m_step) begin nx = TL; crash = 1; end
          else begin
            nx = m_x + dir * m_step;
            nstep = (m_step + 1 > SMAX) ? SMAX : m_step + 1;
          end
        end
        if (!hold) nst = 1;
      end else if (m_st == 4) begin
        if (btn_center) nst = 0;
      end else if (btn_center) begin
        nst = 0; nl = LIVES;
      end
      if (m_st <= 3 && m_riv != 0) crash = 1;
      if (crash) begin
        nl  = m_lives - 1;
        nst = (m_lives == 1) ? 5 : 4;
      end
      if (nst != 2 && nst != 3) nstep = SMIN;
      if (nst == 0) nx = SX;
      m_cnt   = (nst == 0 || tick) ? 0 : m_cnt + 1;
      m_st = nst; m_x = nx; m_step = nstep; m_lives = nl;
      m_riv   = rival_collision;
      m_pulse = crash;
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    @(negedge clk);
    forever begin
      chk("m_state", state, m_st);
      chk("m_car_x", car_x, m_x);
      chk("m_lives", lives_left, m_lives);
      chk("m_pulse", crash_pulse, m_pulse);
      chk("m_running", running, (m_st <= 3) ? 1 : 0);
      chk("m_game_over", game_over, (m_st == 5) ? 1 : 0);
      @(negedge clk);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; btn_left = 0; btn_right = 0; btn_center = 0; rival_collision = 0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic wait_x(input int exp, input string nm);
    int prev;
    bit seen;
    prev = car_x;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (car_x != prev) seen = 1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s: car_x stuck at %0d, expected %0d", nm, car_x, exp);
    end else chk(nm, car_x, exp);
  endtask

  int rseq[10] = '{271, 273, 276, 280, 284, 288, 292, 296, 300, 304};
  int lseq[8]  = '{269, 267, 264, 260, 256, 252, 248, 244};

  initial begin
    cyc(2);
    chk("rst_state", state, 0);
    chk("rst_car_x", car_x, 270);
    chk("rst_lives", lives_left, 3);
    chk("rst_pulse", crash_pulse, 0);
    chk("rst_running", running, 1);
    chk("rst_game_over", game_over, 0);

    // Hold right until the wall.
    do_reset();
    btn_right = 1;
    foreach (rseq[i]) wait_x(rseq[i], "right_seq");
    chk("rwall_state", state, 4);
    chk("rwall_lives", lives_left, 2);
    chk("rwall_pulse", crash_pulse, 1);
    chk("rwall_running", running, 0);
    btn_right = 0;
    cyc(1);
    chk("rwall_pulse_end", crash_pulse, 0);
    chk("rwall_frozen", car_x, 304);
    btn_center = 1; cyc(1); btn_center = 0;
    chk("respawn_start", state, 0);
    cyc(1);
    chk("respawn_idle", state, 1);
    chk("respawn_x", car_x, 270);
    chk("respawn_lives", lives_left, 2);

    // Hold left until the wall.
    do_reset();
    btn_left = 1;
    foreach (lseq[i]) wait_x(lseq[i], "left_seq");
    chk("lwall_state", state, 4);
    chk("lwall_lives", lives_left, 2);

    // Release mid-run resets the step.
    do_reset();
    btn_left = 1;
    wait_x(269, "lrel_1");
    wait_x(267, "lrel_2");
    btn_left = 0; cyc(1);
    chk("lrel_idle", state, 1);
    btn_left = 1;
    wait_x(266, "lrel_step1");
    chk("lrel_left", state, 3);

    // Rival pulse in IDLE.
    do_reset();
    cyc(2);
    chk("rival_pre", state, 1);
    rival_collision = 1; cyc(1); rival_collision = 0;
    chk("rival_edge1", state, 1);
    cyc(1);
    chk("rival_crash", state, 4);
    chk("rival_lives", lives_left, 2);
    chk("rival_x", car_x, 270);
    chk("rival_pulse", crash_pulse, 1);
    btn_center = 1; cyc(1); btn_center = 0;
    chk("rival_start", state, 0);
    cyc(1);
    chk("rival_idle", state, 1);
    chk("rival_idle_x", car_x, 270);

    // Three crashes end the game.
    do_reset();
    cyc(1);
    for (int k = 0; k < 3; k++) begin
      rival_collision = 1; cyc(1); rival_collision = 0; cyc(1);
      if (k < 2) begin
        chk("multi_crash", state, 4);
        btn_center = 1; cyc(1); btn_center = 0; cyc(1);
      end
    end
    chk("over_state", state, 5);
    chk("over_flag", game_over, 1);
    chk("over_lives", lives_left, 0);
    chk("over_running", running, 0);
    btn_center = 1; cyc(1); btn_center = 0;
    chk("newgame_start", state, 0);
    chk("newgame_lives", lives_left, 3);
    cyc(1);
    chk("newgame_x", car_x, 270);
    chk("newgame_running", running, 1);

    // Both buttons, then center ignored while moving.
    do_reset();
    cyc(2);
    btn_left = 1; btn_right = 1;
    cyc(6);
    chk("both_state", state, 1);
    chk("both_x", car_x, 270);
    btn_left = 0; cyc(1);
    chk("right_enter", state, 2);
    btn_center = 1; cyc(2); btn_center = 0;
    chk("center_ignored", state, 2);

    // Asynchronous reset mid-move.
    wait_x(271, "pre_async");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_x", car_x, 270);
    chk("async_state", state, 0);
    chk("async_lives", lives_left, 3);
    chk("async_pulse", crash_pulse, 0);
    cyc(2);
    btn_right = 0;
    reset = 1'b0;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
